axi_id_arbiter: RTL and testbench

- Many-to-one AXI address-channel arbiter, request side of the ID scheme.
- Up to AXI_PORT_NUM masters present valid/ready address channels. One round-robin winner is captured into an output register slice and forwarded with an AXI ID equal to the winner's port index.
- The downstream ID decoder maps that ID back to a one-hot port select for response routing.
- Instantiated once per address channel (AW and AR).

---
 rtl/axi_id_arbiter_pkg.sv | 37 +++
 rtl/axi_id_arbiter_if.sv | 38 +++
 rtl/axi_rr_picker.sv | 40 ++++
 rtl/axi_id_arbiter.sv | 100 ++++++++++
 tb/tb_axi_id_arbiter.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/axi_id_arbiter_pkg.sv
// Shared definitions for the AXI ID request-side arbiter and its ID decoder:
// state encoding, log2 helper and the one-hot expansion used on both sides.
package axi_id_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_BUSY = 1'b1;

    typedef enum logic {
        S_IDLE = ST_IDLE,
        S_BUSY = ST_BUSY
    } state_e;

    localparam int ONEHOT_MAX = 64;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

    // Out-of-range indices expand to all zeros so callers can pass "no winner" safely.
    function automatic logic [ONEHOT_MAX-1:0] onehot(input int index, input int width);
        logic [ONEHOT_MAX-1:0] result;
        result = '0;
        if (index >= 0 && index < width && index < ONEHOT_MAX) begin
            result = ONEHOT_MAX'(1) << index;
        end
        return result;
    endfunction

endpackage

// File: rtl/axi_id_arbiter_if.sv
// Bundle of the per-port request channels and the single arbitrated output channel.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface axi_id_arbiter_if #(
    parameter int AXI_ID_WIDTH  = 2,
    parameter int AXI_PORT_NUM  = 3,
    parameter int PAYLOAD_WIDTH = 32
);
    logic [AXI_PORT_NUM-1:0]               s_valid_i;
    logic [AXI_PORT_NUM-1:0]               s_ready_o;
    logic [AXI_PORT_NUM*PAYLOAD_WIDTH-1:0] s_payload_i;
    logic                                  m_valid_o;
    logic                                  m_ready_i;
    logic [AXI_ID_WIDTH-1:0]               m_id_o;
    logic [PAYLOAD_WIDTH-1:0]              m_payload_o;
    logic [AXI_PORT_NUM-1:0]               gnt_o;

    modport slave (
        input  s_valid_i,
        input  s_payload_i,
        input  m_ready_i,
        output s_ready_o,
        output m_valid_o,
        output m_id_o,
        output m_payload_o,
        output gnt_o
    );

    modport master (
        output s_valid_i,
        output s_payload_i,
        output m_ready_i,
        input  s_ready_o,
        input  m_valid_o,
        input  m_id_o,
        input  m_payload_o,
        input  gnt_o
    );
endinterface

// File: rtl/axi_rr_picker.sv
// Combinational round-robin picker: first requester at or after ptr_i, scanning cyclically.
module axi_rr_picker
    import axi_id_pkg::*;
#(
    parameter  int PORT_NUM = 3,
    localparam int PTR_W    = clog2(PORT_NUM)
) (
    input  logic [PORT_NUM-1:0] req_i,
    input  logic [PTR_W-1:0]    ptr_i,
    output logic                found_o,
    output logic [PTR_W-1:0]    idx_o,
    output logic [PORT_NUM-1:0] onehot_o
);

    logic [PTR_W-1:0] cand    [PORT_NUM];
    logic [PTR_W-1:0] idx_acc [PORT_NUM+1];
    logic [PORT_NUM:0] seen;
    logic [PORT_NUM-1:0] hit;
    logic [PORT_NUM-1:0] take;

    assign seen[0]    = 1'b0;
    assign idx_acc[0] = '0;

    // Offset gi from the pointer maps to port cand[gi]; the lowest hitting offset wins.
    for (genvar gi = 0; gi < PORT_NUM; gi++) begin : g_off
        logic [PTR_W:0] sum;
        assign sum      = {1'b0, ptr_i} + (PTR_W+1)'(gi);
        assign cand[gi] = (sum >= (PTR_W+1)'(PORT_NUM)) ? PTR_W'(sum - (PTR_W+1)'(PORT_NUM))
                                                         : sum[PTR_W-1:0];
        assign hit[gi]         = req_i[cand[gi]];
        assign take[gi]        = hit[gi] & ~seen[gi];
        assign seen[gi+1]      = seen[gi] | hit[gi];
        assign idx_acc[gi+1]   = idx_acc[gi] | (take[gi] ? cand[gi] : '0);
    end

    assign found_o  = seen[PORT_NUM];
    assign idx_o    = idx_acc[PORT_NUM];
    assign onehot_o = found_o ? PORT_NUM'(onehot(int'(idx_o), PORT_NUM)) : '0;

endmodule

// File: rtl/axi_id_arbiter.sv
// Many-to-one AXI address-channel arbiter: round-robin winner is registered into a
// one-deep output slice and tagged with its port index as the AXI ID.
module axi_id_arbiter
    import axi_id_pkg::*;
#(
    parameter int AXI_ID_WIDTH  = 2,
    parameter int AXI_PORT_NUM  = 3,
    parameter int PAYLOAD_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    axi_id_arbiter_if.slave       bus
);

    localparam int PTR_W = clog2(AXI_PORT_NUM);

    if (AXI_ID_WIDTH < PTR_W) begin : g_bad_id
        $fatal(1, "Error: ID width too small");
    end
    if (AXI_PORT_NUM < 2 || AXI_PORT_NUM > ONEHOT_MAX) begin : g_bad_ports
        $fatal(1, "Error: AXI_PORT_NUM out of range");
    end

    state_e                      state_q, state_d;
    logic [PTR_W-1:0]            ptr_q, ptr_d;
    logic [AXI_ID_WIDTH-1:0]     id_q, id_d;
    logic [PAYLOAD_WIDTH-1:0]    payload_q, payload_d;
    logic [AXI_PORT_NUM-1:0]     gnt_q, gnt_d;

    logic                        cap;
    logic                        pick_found;
    logic [PTR_W-1:0]            pick_idx;
    logic [AXI_PORT_NUM-1:0]     pick_onehot;
    logic [PAYLOAD_WIDTH-1:0]    pay_acc [AXI_PORT_NUM+1];

    axi_rr_picker #(
        .PORT_NUM (AXI_PORT_NUM)
    ) u_picker (
        .req_i    (bus.s_valid_i),
        .ptr_i    (ptr_q),
        .found_o  (pick_found),
        .idx_o    (pick_idx),
        .onehot_o (pick_onehot)
    );

    // AND-OR payload mux steered by the one-hot winner.
    assign pay_acc[0] = '0;
    for (genvar gi = 0; gi < AXI_PORT_NUM; gi++) begin : g_pay
        assign pay_acc[gi+1] = pay_acc[gi]
                             | ({PAYLOAD_WIDTH{pick_onehot[gi]}}
                                & bus.s_payload_i[gi*PAYLOAD_WIDTH +: PAYLOAD_WIDTH]);
    end

    assign cap = (state_q == S_IDLE) || bus.m_ready_i;

    // Ready is gated by reset directly so no source sees a handshake while held in reset.
    assign bus.s_ready_o = (cap && pick_found && !rst_i) ? pick_onehot : '0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        payload_d = payload_q;
        gnt_d     = gnt_q;
        if (cap) begin
            if (pick_found) begin
                state_d   = S_BUSY;
                id_d      = AXI_ID_WIDTH'(pick_idx);
                payload_d = pay_acc[AXI_PORT_NUM];
                gnt_d     = pick_onehot;
                ptr_d     = (pick_idx == PTR_W'(AXI_PORT_NUM-1)) ? '0 : pick_idx + PTR_W'(1);
            end else begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            payload_q <= '0;
            gnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            payload_q <= payload_d;
            gnt_q     <= gnt_d;
        end
    end

    assign bus.m_valid_o   = (state_q == S_BUSY);
    assign bus.m_id_o      = id_q;
    assign bus.m_payload_o = payload_q;
    assign bus.gnt_o       = gnt_q;

endmodule

// File: tb/tb_axi_id_arbiter.sv
// Scoreboard bench for axi_id_arbiter: a cyclic-scan reference model predicts every
// captured beat; a negedge monitor compares whatever the DUT presents on its output.
module tb_axi_id_arbiter;

    localparam int N   = 3;
    localparam int IDW = 2;
    localparam int PW  = 32;

    typedef struct {
        int            id;
        logic [PW-1:0] payload;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    axi_id_arbiter_if #(.AXI_ID_WIDTH(IDW), .AXI_PORT_NUM(N), .PAYLOAD_WIDTH(PW)) bus ();

    axi_id_arbiter #(
        .AXI_ID_WIDTH  (IDW),
        .AXI_PORT_NUM  (N),
        .PAYLOAD_WIDTH (PW)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    beat_t         exp_q[$];
    beat_t         pend;
    bit            pend_vld = 1'b0;
    int            m_ptr    = 0;
    bit            m_busy   = 1'b0;
    logic [PW-1:0] pl [N];
    int            vectors     = 0;
    int            miscompares = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // One bus cycle: drive inputs, advance the reference model, check the same-cycle ready.
    task automatic cycle(input logic [N-1:0] v, input logic r, input bit fixed);
        logic [N-1:0] exp_ready;
        int           w;
        @(posedge clk);
        if (pend_vld) begin
            exp_q.push_back(pend);
            pend_vld = 1'b0;
        end
        #1;
        for (int k = 0; k < N; k++) begin
            pl[k] = fixed ? PW'(k * 32'h1000) : PW'($urandom);
            bus.s_payload_i[k*PW +: PW] = pl[k];
        end
        bus.s_valid_i = v;
        bus.m_ready_i = r;
        #1;
        exp_ready = '0;
        w = -1;
        if (!m_busy || r) begin
            for (int off = 0; off < N; off++) begin
                if (w < 0 && v[(m_ptr + off) % N]) w = (m_ptr + off) % N;
            end
            if (w >= 0) begin
                exp_ready[w] = 1'b1;
                pend.id      = w;
                pend.payload = pl[w];
                pend_vld     = 1'b1;
                m_ptr        = (w + 1) % N;
                m_busy       = 1'b1;
            end else begin
                m_busy = 1'b0;
            end
        end
        check("s_ready", 64'(bus.s_ready_o), 64'(exp_ready));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (bus.m_valid_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("valid_without_beat", 64'(bus.m_valid_o), 64'(0));
                end else begin
                    $display("beat id=%0d payload=0x%08h ready=%0b", bus.m_id_o, bus.m_payload_o, bus.m_ready_i);
                    check("m_id", 64'(bus.m_id_o), 64'(exp_q[0].id));
                    check("m_payload", 64'(bus.m_payload_o), 64'(exp_q[0].payload));
                    check("gnt", 64'(bus.gnt_o), 64'(1) << exp_q[0].id);
                    if (bus.m_ready_i) void'(exp_q.pop_front());
                end
            end else begin
                check("idle_valid", 64'(bus.m_valid_o), 64'(0));
                check("idle_gnt", 64'(bus.gnt_o), 64'(0));
                check("missing_beat", 64'(exp_q.size()), 64'(0));
            end
        end
    end

    initial begin
        bus.s_valid_i   = '0;
        bus.m_ready_i   = 1'b0;
        bus.s_payload_i = '0;

        // Reset values, and no ready while reset is held even with everything requesting.
        repeat (3) @(posedge clk);
        #1;
        bus.s_valid_i = '1;
        bus.m_ready_i = 1'b1;
        #1;
        check("rst_s_ready", 64'(bus.s_ready_o), 64'(0));
        check("rst_m_valid", 64'(bus.m_valid_o), 64'(0));
        check("rst_m_id", 64'(bus.m_id_o), 64'(0));
        check("rst_m_payload", 64'(bus.m_payload_o), 64'(0));
        check("rst_gnt", 64'(bus.gnt_o), 64'(0));
        bus.s_valid_i = '0;
        bus.m_ready_i = 1'b0;
        rst = 1'b0;

        // Single request on port 1, then drain.
        cycle(3'b010, 1'b1, 1'b1);
        cycle(3'b000, 1'b1, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);

        // All valid starting from ptr=2.
        repeat (6) cycle(3'b111, 1'b1, 1'b0);

        // Reset while a beat is held under backpressure.
        cycle(3'b001, 1'b0, 1'b0);
        cycle(3'b000, 1'b0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        check("arst_m_valid", 64'(bus.m_valid_o), 64'(0));
        check("arst_m_id", 64'(bus.m_id_o), 64'(0));
        check("arst_m_payload", 64'(bus.m_payload_o), 64'(0));
        check("arst_gnt", 64'(bus.gnt_o), 64'(0));
        check("arst_s_ready", 64'(bus.s_ready_o), 64'(0));
        exp_q.delete();
        pend_vld = 1'b0;
        m_busy   = 1'b0;
        m_ptr    = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        repeat (2) cycle(3'b000, 1'b0, 1'b0);

        // All valid from reset: ids 0,1,2,0,1,2 back to back.
        repeat (6) cycle(3'b111, 1'b1, 1'b0);

        // Backpressure on an id=2 beat, then wrap to port 0.
        cycle(3'b100, 1'b1, 1'b0);
        repeat (4) cycle(3'b011, 1'b0, 1'b0);
        cycle(3'b011, 1'b1, 1'b0);
        cycle(3'b000, 1'b1, 1'b0);

        // Port 0 hogging, port 2 requesting once.
        cycle(3'b001, 1'b1, 1'b0);
        cycle(3'b101, 1'b1, 1'b0);
        repeat (4) cycle(3'b001, 1'b1, 1'b0);

        // Drain to idle.
        cycle(3'b001, 1'b1, 1'b0);
        repeat (2) cycle(3'b000, 1'b1, 1'b0);

        // Randomized traffic with random backpressure.
        repeat (1500) cycle(N'($urandom_range(0, (1 << N) - 1)), ($urandom_range(0, 3) != 0), 1'b0);

        repeat (4) cycle(3'b000, 1'b1, 1'b0);
        @(negedge clk);
        #1;
        check("final_queue", 64'(exp_q.size()), 64'(0));
        check("final_valid", 64'(bus.m_valid_o), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
